mic3_spi_responder: RTL and testbench

// - SPI responder emulating the Pmod MIC3 ADC output (ADCS7476-style 16-bit read frame) for the on-board mic3 master.
// - Core logic supplies 12-bit samples through a valid/ready handshake.
// - Samples are shifted out on MISO whenever the master drops CS.
// - Enables loopback testing of the mic3 interface without the microphone, e.g. DA2 test board fed by a known pattern.

---
 rtl/mic3_spi_responder.sv | 212 +++++++++++++++++++++
 tb/tb_mic3_spi_responder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mic3_spi_responder.sv
// SPI responder that emulates the Pmod MIC3 ADC 16-bit read frame, fed by a 12-bit sample handshake.
// Optional feature: define MIC3_EMU_UNDERRUN_EN to add underrun / underrun_sticky outputs.
module mic3_spi_responder #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        IDLE_MISO   = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] sample_in,
   input  logic        sample_valid,
   output logic        sample_ready,
   input  logic        CS,
   input  logic        SCLK,
   output logic        MISO,
   output logic        MISO_oe,
   output logic        frame_done,
   output logic        aborted
`ifdef MIC3_EMU_UNDERRUN_EN
   ,
   output logic        underrun,
   output logic        underrun_sticky
`endif
);

   localparam int unsigned SAMPLE_W = 12;
   localparam int unsigned FRAME_W  = 16;
   localparam int unsigned CNT_W    = 4;
   localparam int unsigned PAD_W    = FRAME_W - SAMPLE_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic                   cs_prev_q, sclk_prev_q;
   logic                   cs_s, sclk_s;
   logic                   cs_fall, cs_rise, sclk_fall;

   state_t                 state_q, state_d;
   logic [FRAME_W-1:0]     shift_q, shift_d;
   logic [CNT_W-1:0]       bitcnt_q, bitcnt_d;
   logic                   miso_q, miso_d;
   logic                   miso_oe_q, miso_oe_d;
   logic                   frame_done_q, frame_done_d;
   logic                   aborted_q, aborted_d;
   logic [SAMPLE_W-1:0]    hold_q, hold_d;
   logic                   ready_q, ready_d;
   logic [SAMPLE_W-1:0]    last_q, last_d;
   logic                   load;
   logic [SAMPLE_W-1:0]    word_sel;
   logic [FRAME_W-1:0]     frame_word;
`ifdef MIC3_EMU_UNDERRUN_EN
   logic                   underrun_q, underrun_d;
   logic                   sticky_q, sticky_d;
`endif

   // Synchronisers shift the async pins in at the LSB; the MSB is the clean copy.
   always_comb begin
      if (SYNC_STAGES > 1) begin
         cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], CS};
         sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      end else begin
         cs_sync_d   = {SYNC_STAGES{CS}};
         sclk_sync_d = {SYNC_STAGES{SCLK}};
      end
   end

   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign cs_fall   = cs_prev_q & ~cs_s;
   assign cs_rise   = ~cs_prev_q & cs_s;
   assign sclk_fall = sclk_prev_q & ~sclk_s;

   // Next-state, shifter and holding-register logic.
   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      bitcnt_d     = bitcnt_q;
      miso_d       = miso_q;
      miso_oe_d    = miso_oe_q;
      frame_done_d = 1'b0;
      aborted_d    = 1'b0;
      hold_d       = hold_q;
      ready_d      = ready_q;
      last_d       = last_q;
      load         = 1'b0;
      word_sel     = last_q;
      frame_word   = '0;
`ifdef MIC3_EMU_UNDERRUN_EN
      underrun_d   = 1'b0;
      sticky_d     = sticky_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
               load    = 1'b1;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            // A CS rise outranks a coincident SCLK fall.
            if (cs_rise) begin
               aborted_d = 1'b1;
               miso_oe_d = 1'b0;
               miso_d    = IDLE_MISO;
               state_d   = ST_IDLE;
            end else if (sclk_fall) begin
               if (bitcnt_q == CNT_W'(FRAME_W - 1)) begin
                  miso_oe_d    = 1'b0;
                  miso_d       = IDLE_MISO;
                  frame_done_d = 1'b1;
                  state_d      = ST_DONE;
               end else begin
                  bitcnt_d = bitcnt_q + CNT_W'(1);
                  shift_d  = {shift_q[FRAME_W-2:0], 1'b0};
                  miso_d   = shift_q[FRAME_W-2];
               end
            end
         end
         ST_DONE: begin
            if (cs_rise) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Frame source priority: holding register, same-cycle bypass, then replay.
      if (load) begin
         if (!ready_q) begin
            word_sel = hold_q;
            ready_d  = 1'b1;
         end else if (sample_valid) begin
            word_sel = sample_in;
         end else begin
            word_sel = last_q;
`ifdef MIC3_EMU_UNDERRUN_EN
            underrun_d = 1'b1;
            sticky_d   = 1'b1;
`endif
         end
         frame_word = {{PAD_W{1'b0}}, word_sel};
         last_d     = word_sel;
         shift_d    = frame_word;
         miso_d     = frame_word[FRAME_W-1];
         miso_oe_d  = 1'b1;
         bitcnt_d   = '0;
      end else if (sample_valid && ready_q) begin
         hold_d  = sample_in;
         ready_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cs_sync_q    <= '1;
         sclk_sync_q  <= '1;
         cs_prev_q    <= 1'b1;
         sclk_prev_q  <= 1'b1;
         state_q      <= ST_IDLE;
         shift_q      <= '0;
         bitcnt_q     <= '0;
         miso_q       <= IDLE_MISO;
         miso_oe_q    <= 1'b0;
         frame_done_q <= 1'b0;
         aborted_q    <= 1'b0;
         hold_q       <= '0;
         ready_q      <= 1'b1;
         last_q       <= '0;
`ifdef MIC3_EMU_UNDERRUN_EN
         underrun_q   <= 1'b0;
         sticky_q     <= 1'b0;
`endif
      end else begin
         cs_sync_q    <= cs_sync_d;
         sclk_sync_q  <= sclk_sync_d;
         cs_prev_q    <= cs_s;
         sclk_prev_q  <= sclk_s;
         state_q      <= state_d;
         shift_q      <= shift_d;
         bitcnt_q     <= bitcnt_d;
         miso_q       <= miso_d;
         miso_oe_q    <= miso_oe_d;
         frame_done_q <= frame_done_d;
         aborted_q    <= aborted_d;
         hold_q       <= hold_d;
         ready_q      <= ready_d;
         last_q       <= last_d;
`ifdef MIC3_EMU_UNDERRUN_EN
         underrun_q   <= underrun_d;
         sticky_q     <= sticky_d;
`endif
      end
   end

   assign sample_ready = ready_q;
   assign MISO         = miso_q;
   assign MISO_oe      = miso_oe_q;
   assign frame_done   = frame_done_q;
   assign aborted      = aborted_q;
`ifdef MIC3_EMU_UNDERRUN_EN
   assign underrun        = underrun_q;
   assign underrun_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_mic3_spi_responder.sv
// Bench for mic3_spi_responder: directed frame table, reset mid-frame, and random push/frame traffic.
module tb_mic3_spi_responder;

   localparam int unsigned SYNC = 2;
   localparam logic        IDLE = 1'b0;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [11:0] sample_in = '0;
   logic        sample_valid = 1'b0;
   logic        sample_ready;
   logic        CS = 1'b1;
   logic        SCLK = 1'b1;
   logic        MISO;
   logic        MISO_oe;
   logic        frame_done;
   logic        aborted;
`ifdef MIC3_EMU_UNDERRUN_EN
   logic        underrun;
   logic        underrun_sticky;
`endif

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   int abort_cnt = 0;

   // Reference model: optional pending sample plus last transmitted sample.
   bit          m_full = 1'b0;
   logic [11:0] m_hold = '0;
   logic [11:0] m_last = '0;

   mic3_spi_responder #(.SYNC_STAGES(SYNC), .IDLE_MISO(IDLE)) dut (
      .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
      .sample_ready(sample_ready), .CS(CS), .SCLK(SCLK), .MISO(MISO), .MISO_oe(MISO_oe),
      .frame_done(frame_done), .aborted(aborted)
`ifdef MIC3_EMU_UNDERRUN_EN
      , .underrun(underrun), .underrun_sticky(underrun_sticky)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_done) done_cnt++;
      if (aborted) abort_cnt++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [11:0] v);
      chk("ready_before_push", 32'(sample_ready), 32'(!m_full));
      sample_in = v;
      sample_valid = 1'b1;
      tick(1);
      sample_valid = 1'b0;
      if (!m_full) begin
         m_hold = v;
         m_full = 1'b1;
      end
      chk("ready_after_push", 32'(sample_ready), 32'(!m_full));
   endtask

   // Predicts the next frame word from the model and advances the model.
   task automatic model_frame(input bit byp, input logic [11:0] bv,
                              output logic [15:0] w, output bit und);
      und = 1'b0;
      if (m_full) begin
         w = {4'h0, m_hold};
         m_full = 1'b0;
      end else if (byp) begin
         w = {4'h0, bv};
      end else begin
         w = {4'h0, m_last};
         und = 1'b1;
      end
      m_last = w[11:0];
   endtask

   task automatic frame(input int nf, input bit byp, input logic [11:0] bv,
                        input logic [15:0] exp, input bit exp_und);
      logic [15:0] got;
      int d0, a0;
      got = '0;
      d0 = done_cnt;
      a0 = abort_cnt;
      CS = 1'b0;
      tick(SYNC);
      chk("oe_before_latency", 32'(MISO_oe), 32'(0));
      if (byp) begin
         sample_in = bv;
         sample_valid = 1'b1;
      end
      tick(1);
      sample_valid = 1'b0;
      chk("oe_at_latency", 32'(MISO_oe), 32'(1));
      chk("ready_at_start", 32'(sample_ready), 32'(1));
`ifdef MIC3_EMU_UNDERRUN_EN
      chk("underrun_pulse", 32'(underrun), 32'(exp_und));
      if (exp_und) chk("underrun_sticky", 32'(underrun_sticky), 32'(1));
`else
      if (exp_und) got = '0;
`endif
      tick(2);
      for (int i = 0; i < nf; i++) begin
         got[15-i] = MISO;
         SCLK = 1'b0;
         tick(5);
         SCLK = 1'b1;
         tick(5);
      end
      if (nf < 16) begin
         chk("oe_mid_frame", 32'(MISO_oe), 32'(1));
      end else begin
         chk("oe_after_16", 32'(MISO_oe), 32'(0));
         chk("miso_after_16", 32'(MISO), 32'(IDLE));
      end
      CS = 1'b1;
      tick(SYNC + 3);
      chk("oe_after_cs", 32'(MISO_oe), 32'(0));
      chk("miso_after_cs", 32'(MISO), 32'(IDLE));
      chk("frame_bits", 32'(got >> (16 - nf)), 32'(exp >> (16 - nf)));
      chk("frame_done_count", 32'(done_cnt - d0), 32'(nf == 16));
      chk("aborted_count", 32'(abort_cnt - a0), 32'(nf < 16));
   endtask

   typedef struct {
      bit          do_push;
      logic [11:0] val;
      int          nf;
      bit          byp;
      logic [11:0] bv;
      logic [15:0] exp_word;
      bit          exp_und;
   } vec_t;

   initial begin
      vec_t        vt[8];
      logic [15:0] w;
      bit          und;

      vt[0] = '{1'b0, 12'h000, 16, 1'b0, 12'h000, 16'h0000, 1'b1};
      vt[1] = '{1'b1, 12'hA5C, 16, 1'b0, 12'h000, 16'h0A5C, 1'b0};
      vt[2] = '{1'b1, 12'h123, 16, 1'b0, 12'h000, 16'h0123, 1'b0};
      vt[3] = '{1'b0, 12'h000, 16, 1'b0, 12'h000, 16'h0123, 1'b1};
      vt[4] = '{1'b1, 12'h456,  7, 1'b0, 12'h000, 16'h0456, 1'b0};
      vt[5] = '{1'b1, 12'h789, 16, 1'b0, 12'h000, 16'h0789, 1'b0};
      vt[6] = '{1'b0, 12'h000, 16, 1'b1, 12'hFFF, 16'h0FFF, 1'b0};
      vt[7] = '{1'b0, 12'h000, 16, 1'b0, 12'h000, 16'h0FFF, 1'b1};

      tick(3);
      chk("rst_miso", 32'(MISO), 32'(IDLE));
      chk("rst_oe", 32'(MISO_oe), 32'(0));
      chk("rst_ready", 32'(sample_ready), 32'(1));
      chk("rst_done", 32'(frame_done), 32'(0));
      chk("rst_aborted", 32'(aborted), 32'(0));
      rst = 1'b1;
      tick(3);

      for (int k = 0; k < 8; k++) begin
         if (vt[k].do_push) push(vt[k].val);
         model_frame(vt[k].byp, vt[k].bv, w, und);
         frame(vt[k].nf, vt[k].byp, vt[k].bv, vt[k].exp_word, vt[k].exp_und);
         if (vt[k].byp) chk("bypass_hold_empty", 32'(sample_ready), 32'(1));
      end

      // Reset asserted at bit 9 of a frame.
      push(12'h3C3);
      CS = 1'b0;
      tick(SYNC + 3);
      for (int i = 0; i < 9; i++) begin
         SCLK = 1'b0;
         tick(5);
         SCLK = 1'b1;
         tick(5);
      end
      rst = 1'b0;
      #1;
      chk("midrst_miso", 32'(MISO), 32'(IDLE));
      chk("midrst_oe", 32'(MISO_oe), 32'(0));
      chk("midrst_ready", 32'(sample_ready), 32'(1));
      chk("midrst_done", 32'(frame_done), 32'(0));
      chk("midrst_aborted", 32'(aborted), 32'(0));
      CS = 1'b1;
      m_full = 1'b0;
      m_last = '0;
      tick(2);
      rst = 1'b1;
      tick(3);
      push(12'h5A5);
      model_frame(1'b0, 12'h000, w, und);
      frame(16, 1'b0, 12'h000, 16'h05A5, 1'b0);

      // Random traffic against the model.
      for (int k = 0; k < 25; k++) begin
         if ($urandom_range(0, 2) == 0) begin
            push(12'($urandom));
         end else begin
            int nf;
            bit byp;
            logic [11:0] bv;
            nf  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 16;
            byp = (!m_full) && ($urandom_range(0, 3) == 0);
            bv  = 12'($urandom);
            model_frame(byp, bv, w, und);
            frame(nf, byp, bv, w, und);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
